// File: rtl/nrisk_pkg.sv
// -----------------------------------------------------------------------------
// nrisk_pkg
//
// Shared definitions for the nRisk 8-bit datapath.
//
// Contents:
//   LARGURA_PADRAO - default datapath word width, in bits.
//   estado_br_t    - register bank state:
//                      LIMPANDO = the clear engine is zeroing the bank,
//                      PRONTO   = the bank is usable.
// -----------------------------------------------------------------------------
package nrisk_pkg;

    localparam int unsigned LARGURA_PADRAO = 8;

    typedef enum logic [0:0] {
        LIMPANDO,
        PRONTO
    } estado_br_t;

endpackage

// File: rtl/banco_registradores.sv
// -----------------------------------------------------------------------------
// banco_registradores
//
// Register bank for the nRisk datapath. It has two registered read ports and
// one write port. A write to the register being read in the same cycle is
// bypassed to the read port. Register 0 can optionally be hardwired to zero.
// A sequential clear engine zeroes the whole bank after reset, and again
// whenever a clear is requested.
//
// Parameters:
//   LARGURA  - bits per register.
//   NREG     - register count. Must be a power of two and at least 2.
//   R0_ZERO  - 1: register 0 always reads 0 and ignores writes.
//              0: register 0 is an ordinary register.
//
// Ports:
//   clock          in   single clock; all state changes on its rising edge
//   reset          in   synchronous, active-high reset
//   limpar         in   request a full bank clear (sampled only when ready)
//   sinal          in   write enable
//   reg_escrita    in   write address
//   valor_escrita  in   write data
//   reg_leitura_a  in   read address, port A
//   reg_leitura_b  in   read address, port B
//   valor_a        out  registered read data, port A
//   valor_b        out  registered read data, port B
//   pronto         out  1 = bank usable
// -----------------------------------------------------------------------------
module banco_registradores
    import nrisk_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO,
    parameter int unsigned NREG    = 4,
    parameter bit          R0_ZERO = 1'b1,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpar,
    input  logic               sinal,
    input  logic [AW-1:0]      reg_escrita,
    input  logic [LARGURA-1:0] valor_escrita,
    input  logic [AW-1:0]      reg_leitura_a,
    input  logic [AW-1:0]      reg_leitura_b,
    output logic [LARGURA-1:0] valor_a,
    output logic [LARGURA-1:0] valor_b,
    output logic               pronto
);

    // Check the parameters when the design is built.
    if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_nreg_invalido
        $error("banco_registradores: NREG must be a power of two >= 2");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [LARGURA-1:0] b [NREG];

    estado_br_t         estado_q, estado_d;
    logic [AW-1:0]      ponteiro_q, ponteiro_d;
    logic               pronto_d;
    logic [LARGURA-1:0] valor_a_d, valor_b_d;

    // Write actually performed this cycle. A clear request in the same cycle
    // discards the write. A write to register 0 is dropped when that register
    // is hardwired.
    logic escrita_ok;
    logic ultimo;

    assign escrita_ok = (estado_q == PRONTO) && sinal && !limpar &&
                        !(R0_ZERO && (reg_escrita == '0));

    assign ultimo = (ponteiro_q == AW'(NREG - 1));

    // -------------------------------------------------------------------------
    // Read with bypass. All inputs are passed as arguments, so the caller's
    // always_comb sees every dependency.
    // -------------------------------------------------------------------------
    function automatic logic [LARGURA-1:0] ler(
        input logic [AW-1:0]      endereco,
        input logic [LARGURA-1:0] palavra,
        input logic               escreve,
        input logic [AW-1:0]      end_escrita,
        input logic [LARGURA-1:0] dado_escrita
    );
        logic [LARGURA-1:0] resultado;
        if (R0_ZERO && (endereco == '0)) begin
            resultado = '0;
        end else if (escreve && (endereco == end_escrita)) begin
            resultado = dado_escrita;
        end else begin
            resultado = palavra;
        end
        return resultado;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        estado_d   = estado_q;
        ponteiro_d = ponteiro_q;
        valor_a_d  = '0;
        valor_b_d  = '0;

        unique case (estado_q)
            LIMPANDO: begin
                // Clear one word per cycle. The last word hands over to PRONTO.
                // Read data stays at zero for the whole clear.
                ponteiro_d = ponteiro_q + AW'(1);
                if (ultimo) begin
                    estado_d = PRONTO;
                end
            end
            PRONTO: begin
                if (limpar) begin
                    estado_d   = LIMPANDO;
                    ponteiro_d = '0;
                end
                valor_a_d = ler(reg_leitura_a, b[reg_leitura_a], escrita_ok,
                                reg_escrita, valor_escrita);
                valor_b_d = ler(reg_leitura_b, b[reg_leitura_b], escrita_ok,
                                reg_escrita, valor_escrita);
            end
            default: begin
                estado_d   = LIMPANDO;
                ponteiro_d = '0;
            end
        endcase

        // pronto is registered. It goes high on the same edge the FSM enters
        // PRONTO.
        pronto_d = (estado_d == PRONTO);
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= LIMPANDO;
            ponteiro_q <= '0;
            valor_a    <= '0;
            valor_b    <= '0;
            pronto     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            ponteiro_q <= ponteiro_d;
            valor_a    <= valor_a_d;
            valor_b    <= valor_b_d;
            pronto     <= pronto_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage. Reset does not touch the contents; the clear engine that runs
    // right after reset zeroes them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (estado_q == LIMPANDO) begin
                b[ponteiro_q] <= '0;
            end else if (escrita_ok) begin
                b[reg_escrita] <= valor_escrita;
            end
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// -----------------------------------------------------------------------------
// tb_banco_registradores
//
// Drives two banks from the same stimulus: one with register 0 hardwired
// (R0_ZERO = 1) and one without (R0_ZERO = 0). Each stimulus cycle queues the
// outputs expected after the next edge. A checker pops and compares them just
// after that edge.
// -----------------------------------------------------------------------------
module tb_banco_registradores;
    import nrisk_pkg::*;

    logic       clock = 1'b0;
    logic       reset, limpar, sinal;
    logic [1:0] reg_escrita, reg_leitura_a, reg_leitura_b;
    logic [7:0] valor_escrita;
    logic [7:0] valor_a, valor_b, valor_a_n, valor_b_n;
    logic       pronto, pronto_n;

    always #5 clock = ~clock;

    banco_registradores #(
        .LARGURA (8),
        .NREG    (4),
        .R0_ZERO (1'b1)
    ) dut_zero (
        .clock         (clock),
        .reset         (reset),
        .limpar        (limpar),
        .sinal         (sinal),
        .reg_escrita   (reg_escrita),
        .valor_escrita (valor_escrita),
        .reg_leitura_a (reg_leitura_a),
        .reg_leitura_b (reg_leitura_b),
        .valor_a       (valor_a),
        .valor_b       (valor_b),
        .pronto        (pronto)
    );

    banco_registradores #(
        .LARGURA (8),
        .NREG    (4),
        .R0_ZERO (1'b0)
    ) dut_normal (
        .clock         (clock),
        .reset         (reset),
        .limpar        (limpar),
        .sinal         (sinal),
        .reg_escrita   (reg_escrita),
        .valor_escrita (valor_escrita),
        .reg_leitura_a (reg_leitura_a),
        .reg_leitura_b (reg_leitura_b),
        .valor_a       (valor_a_n),
        .valor_b       (valor_b_n),
        .pronto        (pronto_n)
    );

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] an;
        logic [7:0] bn;
        logic       p;
    } esperado_t;

    esperado_t fila[$];
    int erros = 0;
    int total = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    // Checker: pops the expectation queued for the edge that just occurred.
    always @(posedge clock) begin
        esperado_t e;
        #1;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            verifica({e.tag, ".valor_a"},  32'(valor_a),   32'(e.a));
            verifica({e.tag, ".valor_b"},  32'(valor_b),   32'(e.b));
            verifica({e.tag, ".pronto"},   32'(pronto),    32'(e.p));
            verifica({e.tag, ".n.valor_a"}, 32'(valor_a_n), 32'(e.an));
            verifica({e.tag, ".n.valor_b"}, 32'(valor_b_n), 32'(e.bn));
            verifica({e.tag, ".n.pronto"},  32'(pronto_n),  32'(e.p));
        end
    end

    // Drive one cycle's inputs at the falling edge and queue what both banks
    // must show after the following rising edge.
    task automatic passo(
        input logic       rst, input logic l, input logic s,
        input logic [1:0] we, input logic [7:0] wd,
        input logic [1:0] ra, input logic [1:0] rb,
        input logic [7:0] ea, input logic [7:0] eb,
        input logic [7:0] ean, input logic [7:0] ebn,
        input logic       ep, input string tag
    );
        esperado_t e;
        @(negedge clock);
        reset         = rst;
        limpar        = l;
        sinal         = s;
        reg_escrita   = we;
        valor_escrita = wd;
        reg_leitura_a = ra;
        reg_leitura_b = rb;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        e.an  = ean;
        e.bn  = ebn;
        e.p   = ep;
        fila.push_back(e);
    endtask

    initial begin
        reset = 1'b1; limpar = 1'b0; sinal = 1'b0;
        reg_escrita = 2'd0; valor_escrita = 8'h00;
        reg_leitura_a = 2'd0; reg_leitura_b = 2'd0;

        passo(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
              "reset");
        // pronto rises on the 4th edge after reset is released.
        for (int i = 0; i < 4; i++)
            passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00,
                  (i == 3), "limpeza_inicial");
        for (int i = 0; i < 4; i++)
            passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'(i), 2'(i), 8'h00, 8'h00, 8'h00, 8'h00,
                  1'b1, "leitura_zero");

        // Write, then read one cycle later.
        passo(1'b0, 1'b0, 1'b1, 2'd2, 8'hA5, 2'd0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1,
              "escrita_r2");
        passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b1,
              "leitura_r2");
        // Same-cycle bypass to both ports.
        passo(1'b0, 1'b0, 1'b1, 2'd1, 8'h3C, 2'd1, 2'd1, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b1,
              "bypass_r1");
        // Register 0: hardwired bank reads 0; ordinary bank stores and bypasses.
        passo(1'b0, 1'b0, 1'b1, 2'd0, 8'hFF, 2'd0, 2'd2, 8'h00, 8'hA5, 8'hFF, 8'hA5, 1'b1,
              "escrita_r0");
        passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h3C, 8'hFF, 8'h3C, 1'b1,
              "leitura_r0");

        // Load r1..r3.
        passo(1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 2'd0, 2'd2, 8'h00, 8'hA5, 8'hFF, 8'hA5, 1'b1,
              "carga_r1");
        passo(1'b0, 1'b0, 1'b1, 2'd2, 8'h22, 2'd1, 2'd0, 8'h11, 8'h00, 8'h11, 8'hFF, 1'b1,
              "carga_r2");
        passo(1'b0, 1'b0, 1'b1, 2'd3, 8'h33, 2'd2, 2'd3, 8'h22, 8'h33, 8'h22, 8'h33, 1'b1,
              "carga_r3");
        // Clear request: the simultaneous write is discarded (no bypass). Reads
        // still update, and pronto falls on this edge.
        passo(1'b0, 1'b1, 1'b1, 2'd3, 8'h77, 2'd3, 2'd1, 8'h33, 8'h11, 8'h33, 8'h11, 1'b0,
              "limpar_pulso");
        // Clear window: writes and a repeated limpar are ignored, and reads are 0.
        for (int i = 0; i < 4; i++)
            passo(1'b0, (i == 1), 1'b1, 2'd2, 8'h99, 2'd3, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00,
                  (i == 3), "janela_limpeza");
        for (int i = 0; i < 4; i++)
            passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'(i), 2'(3 - i), 8'h00, 8'h00, 8'h00,
                  8'h00, 1'b1, "pos_limpeza");

        // Reset while ponteiro = 2 restarts the full clear.
        passo(1'b0, 1'b0, 1'b1, 2'd3, 8'h5A, 2'd2, 2'd3, 8'h00, 8'h5A, 8'h00, 8'h5A, 1'b1,
              "bypass_b_r3");
        passo(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0,
              "limpar_2");
        passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
              "limpeza_p1");
        passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
              "limpeza_p2");
        passo(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
              "reset_meio");
        for (int i = 0; i < 4; i++)
            passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00,
                  (i == 3), "limpeza_pos_reset");

        passo(1'b0, 1'b0, 1'b1, 2'd2, 8'hC3, 2'd2, 2'd3, 8'hC3, 8'h00, 8'hC3, 8'h00, 1'b1,
              "bypass_a_final");
        passo(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 1'b1,
              "leitura_final");

        @(posedge clock);
        #2;
        verifica("fila_vazia", 32'(fila.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", erros, total);
        $finish;
    end

endmodule

// File: doc/banco_registradores.md
# banco_registradores

Parametrised register bank for the nRisk 8-bit datapath. Two synchronous read ports and one write port per clock edge, write-to-read bypass, optional hardwired-zero register 0, and a sequential clear engine that zeroes the whole bank after reset or on request. It sits between decode (register addresses) and the ALU/writeback stage.

## Interface
Parameters:
- `LARGURA`, 8: bits per register.
- `NREG`, 4: register count; power of two, ≥ 2. `AW = $clog2(NREG)`.
- `R0_ZERO`, 1: 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- Clock and reset: one clock, `clock`; synchronous, active-high reset, `reset`.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `limpar`  in  1  request a full bank clear; sampled only in PRONTO.
- `sinal`  in  1  write enable.
- `reg_escrita`  in  AW  write address.
- `valor_escrita`  in  LARGURA  write data.
- `reg_leitura_a`  in  AW  read address, port A.
- `reg_leitura_b`  in  AW  read address, port B.
- `valor_a`  out  LARGURA  registered read data, port A.
- `valor_b`  out  LARGURA  registered read data, port B.
- `pronto`  out  1  1 = bank usable (state PRONTO).

## Operation
- Two-state FSM: LIMPANDO, PRONTO. An AW-bit `ponteiro` drives the clear.
- Reset: state = LIMPANDO, `ponteiro` = 0, `valor_a` = `valor_b` = 0, `pronto` = 0. Register contents are not cleared by reset itself; the clear engine clears them.
- LIMPANDO: each cycle, write 0 into `b[ponteiro]`, then increment `ponteiro`. At `ponteiro == NREG-1`, that cycle's clear completes and the next state is PRONTO. `sinal` and `limpar` are ignored. Read outputs are held at 0.
- PRONTO, `limpar` = 1: next state is LIMPANDO and `ponteiro` = 0. A same-cycle write is discarded. Read outputs update normally that cycle.
- PRONTO, `sinal` = 1: `b[reg_escrita] <= valor_escrita`. Exception: the write is dropped when `R0_ZERO` = 1 and `reg_escrita` = 0.
- Reads, PRONTO only: `valor_x <= b[reg_leitura_x]` for each port x.
  - Bypass: if `sinal` = 1 and `reg_leitura_x == reg_escrita` in the same cycle, and the write is not dropped, then `valor_x <= valor_escrita`.
  - Register 0 with `R0_ZERO` = 1 always reads 0.
- Both ports may read the same address; both return identical data.
- `ponteiro` wraps naturally at `NREG-1`; it is never used outside LIMPANDO.

## Timing
- Read latency 1 cycle: the address is presented in cycle n, data is on `valor_x` after edge n, stable through cycle n+1.
- Write visible 1 cycle after its edge. It is visible in the same edge via bypass.
- Clear duration: exactly `NREG` cycles from the first LIMPANDO cycle to `pronto` = 1.
  - After reset deasserts, `pronto` rises on the `NREG`-th edge.
  - After `limpar`, `pronto` falls on the next edge and rises `NREG` edges later.
- `reset` asserted mid-clear: `ponteiro` restarts at 0 and the full `NREG`-cycle clear repeats.
- `reset` has priority over `limpar`, which has priority over `sinal`.
- No combinational path from any input to any output.

## Structure
- Shared package `nrisk_pkg`:
  - `LARGURA_PADRAO` = 8.
  - enum `estado_br_t` {LIMPANDO, PRONTO}.
- Storage is an array `b[NREG]` of `LARGURA`-bit words.
- Single module; the FSM and clear pointer are inline (≈20 lines), so no sub-module is needed.
- Read-port logic is identical for A and B. A generate loop or a local function for read-with-bypass is acceptable.

## Test plan
Defaults `LARGURA` = 8, `NREG` = 4, `R0_ZERO` = 1 unless stated.
- Reset then idle → `pronto` = 0 for 4 edges, 1 from the 4th. Reads of r0–r3 return 0x00.
- Clear completes; write r2 = 0xA5, next cycle read A = r2 → `valor_a` = 0xA5 one cycle later.
- Same-cycle write r1 = 0x3C with read A = r1, B = r1 → both = 0x3C after that edge (bypass).
- Write r0 = 0xFF, read r0 → 0x00. Repeat with `R0_ZERO` = 0 → 0xFF.
- Load r1..r3 = 0x11, 0x22, 0x33; pulse `limpar` with a simultaneous write r3 = 0x77 → `pronto` low for 4 cycles. During that window, `sinal` writes are ignored and reads are 0. Afterwards all registers read 0x00.
- Assert `reset` at `ponteiro` = 2 mid-clear → `pronto` stays low 4 more edges after reset release.
